// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 4-bit ALU: valid/ready arbitration,
// a single registered response slot tagged with the requester id, and per-requester completion counters.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op1,
  input  logic [3:0] req0_op2,
  input  logic [2:0] req0_opcode,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op1,
  input  logic [3:0] req1_op2,
  input  logic [2:0] req1_opcode,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_zero,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  function automatic logic [3:0] alu_eval(input logic [2:0] opcode,
                                          input logic [3:0] op1,
                                          input logic [3:0] op2);
    logic [3:0] res;
    case (opcode)
      3'b000:  res = 4'd0;
      3'b001:  res = op1 + op2;
      3'b010:  res = op1 - op2;
      3'b011:  res = op1 & op2;
      3'b100:  res = op1 | op2;
      3'b101:  res = ~op1;
      3'b110:  res = ~op2;
      default: res = 4'd0;
    endcase
    return res;
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic       last_grant_r;
  logic       winner_s;
  logic       can_accept_s;
  logic       xfer_s;
  logic       drain_s;
  logic [3:0] alu_res_s;

  // Winner selection; with both valid the RR mode favours the one not served last.
  always_comb begin
    winner_s = 1'b0;
    if (req0_valid && !req1_valid) begin
      winner_s = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      winner_s = 1'b1;
    end else if (req0_valid && req1_valid) begin
      if (RR_EN) begin
        winner_s = ~last_grant_r;
      end else begin
        winner_s = 1'b0;
      end
    end else begin
      winner_s = 1'b0;
    end
  end

  // Only the granted requester's operands reach the ALU.
  always_comb begin
    alu_res_s = 4'd0;
    if (winner_s) begin
      alu_res_s = alu_eval(req1_opcode, req1_op1, req1_op2);
    end else begin
      alu_res_s = alu_eval(req0_opcode, req0_op1, req0_op2);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (xfer_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (drain_s && !xfer_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Output logic: a draining response frees the slot in the same cycle.
  always_comb begin
    rsp_valid    = (state_r == FULL);
    can_accept_s = !rsp_valid || rsp_ready;
    req0_ready   = can_accept_s && (winner_s == 1'b0);
    req1_ready   = can_accept_s && (winner_s == 1'b1);
    xfer_s       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    drain_s      = rsp_valid && rsp_ready;
  end

  // Response slot and grant history, updated only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data     <= 4'd0;
      rsp_id       <= 1'b0;
      rsp_zero     <= 1'b1;
      last_grant_r <= 1'b1;
    end else if (xfer_s) begin
      rsp_data     <= alu_res_s;
      rsp_id       <= winner_s;
      rsp_zero     <= (alu_res_s == 4'd0);
      last_grant_r <= winner_s;
    end else begin
      rsp_data     <= rsp_data;
      rsp_id       <= rsp_id;
      rsp_zero     <= rsp_zero;
      last_grant_r <= last_grant_r;
    end
  end

  // Saturating completion counters, credited to the id of the response being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else if (drain_s) begin
      if (rsp_id == 1'b0) begin
        if (cnt0 != 8'd255) begin
          cnt0 <= cnt0 + 8'd1;
        end else begin
          cnt0 <= cnt0;
        end
      end else begin
        if (cnt1 != 8'd255) begin
          cnt1 <= cnt1 + 8'd1;
        end else begin
          cnt1 <= cnt1;
        end
      end
    end else begin
      cnt0 <= cnt0;
      cnt1 <= cnt1;
    end
  end

endmodule
